// File: rtl/shiftsub_div.sv
// rtl/shiftsub_div.sv - sequential unsigned restoring (shift-subtract) divider
//
// Purpose:
//   Divides an n-bit unsigned dividend by an n-bit unsigned divisor and
//   produces one quotient bit per clock. A request is taken on start while
//   idle or done. The quotient and remainder appear with a level stop flag,
//   which stays high until the next accepted request. A zero divisor
//   finishes on the accept edge. In that case the quotient is all ones, the
//   remainder is the dividend and div_by_zero is set.
//
// Ports:
//   clk          in   1  rising-edge clock
//   reset        in   1  asynchronous active-low reset
//   start        in   1  operation request, sampled on posedge clk
//   i_dividend   in   n  unsigned dividend, captured on accept
//   i_divisor    in   n  unsigned divisor, captured on accept
//   busy         out  1  iteration sequence running
//   stop         out  1  result valid (level)
//   o_Q          out  n  quotient
//   o_R          out  n  remainder
//   div_by_zero  out  1  captured divisor was zero (valid with stop)

module shiftsub_div #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] i_dividend,
    input  logic [n-1:0] i_divisor,
    output logic         busy,
    output logic         stop,
    output logic [n-1:0] o_Q,
    output logic [n-1:0] o_R,
    output logic         div_by_zero
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    // Working registers: partial remainder, quotient/dividend shifter,
    // captured divisor and the remaining-iteration counter.
    logic [n:0]      r_rw;
    logic [n-1:0]    r_qw;
    logic [n-1:0]    r_dw;
    logic [CW-1:0]   r_cnt;

    logic [n-1:0]    r_q;
    logic [n-1:0]    r_r;
    logic            r_stop;
    logic            r_dz;

    logic            w_accept;
    logic            w_div_zero;
    logic            w_last;
    logic [n+1:0]    w_shifted;
    logic [n+1:0]    w_trial;
    logic            w_fits;
    logic [n:0]      w_rw_next;
    logic [n-1:0]    w_qw_next;

    // One restoring step. The partial remainder is shifted left and takes
    // the MSB of the dividend shifter. The subtraction is two bits wider
    // than the divisor, so its MSB is a clean borrow/sign bit.
    always_comb begin
        w_accept   = (r_state != RUN) && start;
        w_div_zero = (i_divisor == '0);
        w_last     = (r_cnt == CW'(1));
        w_shifted  = {r_rw, r_qw[n-1]};
        w_trial    = w_shifted - {2'b00, r_dw};
        w_fits     = ~w_trial[n+1];
        w_rw_next  = w_fits ? w_trial[n:0] : w_shifted[n:0];
        w_qw_next  = {r_qw[n-2:0], w_fits};
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_next_state = w_div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rw   <= '0;
            r_qw   <= '0;
            r_dw   <= '0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_stop <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        // o_Q/o_R keep the previous result until the new
                        // one is written. Only the flags drop now.
                        r_stop <= 1'b0;
                        r_dz   <= 1'b0;
                        if (w_div_zero) begin
                            r_q    <= '1;
                            r_r    <= i_dividend;
                            r_dz   <= 1'b1;
                            r_stop <= 1'b1;
                        end else begin
                            r_rw  <= '0;
                            r_qw  <= i_dividend;
                            r_dw  <= i_divisor;
                            r_cnt <= CW'(n);
                        end
                    end
                end
                RUN: begin
                    r_rw  <= w_rw_next;
                    r_qw  <= w_qw_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_q    <= w_qw_next;
                        r_r    <= w_rw_next[n-1:0];
                        r_stop <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (r_state == RUN);
    assign stop        = r_stop;
    assign o_Q         = r_q;
    assign o_R         = r_r;
    assign div_by_zero = r_dz;

endmodule

// File: tb/tb_shiftsub_div.sv
// tb/tb_shiftsub_div.sv - scoreboard testbench for shiftsub_div
module tb_shiftsub_div;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dvd;
    logic [N-1:0] dvs;
    logic         busy;
    logic         stop;
    logic [N-1:0] oq;
    logic [N-1:0] orr;
    logic         dz;

    shiftsub_div #(.n(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .i_dividend  (dvd),
        .i_divisor   (dvs),
        .busy        (busy),
        .stop        (stop),
        .o_Q         (oq),
        .o_R         (orr),
        .div_by_zero (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint a;
        longint b;
        longint q;
        longint r;
        longint z;
        int     done_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain integer division with the zero-divisor rule.
    task automatic push_exp(input longint a, input longint b, input int accept_edge);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = (longint'(1) << N) - 1;
            e.r = a;
            e.z = 1;
            e.done_cyc = accept_edge;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 0;
            e.done_cyc = accept_edge + N;
        end
        sb.push_back(e);
    endtask

    // Monitor: a new result is presented when stop rises, or when stop is
    // high right after an edge that accepted a request.
    logic prev_stop = 1'b0;
    logic prev_acc  = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1) begin
            check("busy_stop_exclusive", longint'(busy && stop), 0);
            if (stop && (!prev_stop || prev_acc)) begin
                check("result_expected", longint'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("quotient", longint'(oq), e.q);
                    check("remainder", longint'(orr), e.r);
                    check("div_by_zero", longint'(dz), e.z);
                    check("latency_edge", longint'(cyc), longint'(e.done_cyc));
                    if (e.z == 0) begin
                        check("invariant_qd_r", longint'(oq) * e.b + longint'(orr), e.a);
                        check("invariant_r_lt_d", longint'(longint'(orr) < e.b), 1);
                    end
                end
            end
        end
        prev_stop = stop;
        prev_acc  = start && !busy && (reset === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 1000) begin
            tick();
            guard++;
        end
    endtask

    task automatic issue(input longint a, input longint b);
        tick();
        dvd   = N'(a);
        dvs   = N'(b);
        start = 1'b1;
        push_exp(a, b, cyc + 1);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int i;
        i = 0;
        while (sb.size() != 0 && i < bound) begin
            tick();
            i++;
        end
        check("drain_in_time", longint'(sb.size()), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1;
        int e2;
        int e3;
        int bc;
        longint a;
        longint b;
        int mode;

        reset = 1'b0;
        start = 1'b0;
        dvd   = '0;
        dvs   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", longint'(busy), 0);
        check("rst_stop", longint'(stop), 0);
        check("rst_q", longint'(oq), 0);
        check("rst_r", longint'(orr), 0);
        check("rst_dz", longint'(dz), 0);
        reset = 1'b1;
        repeat (3) tick();
        check("post_rst_idle_busy", longint'(busy), 0);
        check("post_rst_idle_stop", longint'(stop), 0);

        // 100/7 with a one-cycle start pulse; count busy cycles.
        tick();
        dvd = N'(100);
        dvs = N'(7);
        start = 1'b1;
        push_exp(100, 7, cyc + 1);
        tick();
        start = 1'b0;
        bc = 0;
        for (int i = 0; i < 3 * N; i++) begin
            if (busy) bc++;
            if (stop) break;
            tick();
        end
        check("busy_cycles", longint'(bc), N);
        repeat (3) tick();
        check("done_hold_q", longint'(oq), 14);
        check("done_hold_r", longint'(orr), 2);
        check("done_hold_stop", longint'(stop), 1);
        wait_drain(4 * N);

        // Back-to-back with start held high: 255/1, 5/9, 0/3.
        tick();
        dvd = N'(255);
        dvs = N'(1);
        start = 1'b1;
        e1 = cyc + 1;
        push_exp(255, 1, e1);
        run_to(e1);
        dvd = N'(5);
        dvs = N'(9);
        e2 = e1 + N + 1;
        push_exp(5, 9, e2);
        run_to(e1 + N);
        check("b2b_stop_high", longint'(stop), 1);
        run_to(e2);
        check("b2b_stop_one_cycle", longint'(stop), 0);
        dvd = N'(0);
        dvs = N'(3);
        e3 = e2 + N + 1;
        push_exp(0, 3, e3);
        run_to(e3);
        start = 1'b0;
        wait_drain(4 * N);

        // 77/0: finishes on the accept edge, busy never asserts.
        tick();
        dvd = N'(77);
        dvs = N'(0);
        start = 1'b1;
        push_exp(77, 0, cyc + 1);
        tick();
        start = 1'b0;
        check("dz_busy_low", longint'(busy), 0);
        check("dz_stop", longint'(stop), 1);
        check("dz_flag", longint'(dz), 1);
        wait_drain(4);

        // Start during RUN is ignored.
        tick();
        dvd = N'(200);
        dvs = N'(13);
        start = 1'b1;
        e1 = cyc + 1;
        push_exp(200, 13, e1);
        run_to(e1);
        start = 1'b0;
        run_to(e1 + 3);
        dvd = N'(9);
        dvs = N'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_drain(4 * N);

        // Asynchronous reset mid-clock during RUN.
        tick();
        dvd = N'(200);
        dvs = N'(13);
        start = 1'b1;
        e1 = cyc + 1;
        push_exp(200, 13, e1);
        run_to(e1);
        start = 1'b0;
        run_to(e1 + 4);
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        check("arst_busy", longint'(busy), 0);
        check("arst_stop", longint'(stop), 0);
        check("arst_q", longint'(oq), 0);
        check("arst_r", longint'(orr), 0);
        check("arst_dz", longint'(dz), 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("arst_no_restart", longint'(busy), 0);
        issue(40, 6);
        wait_drain(4 * N);

        // Random sweep.
        for (int k = 0; k < 3000; k++) begin
            mode = $urandom_range(0, 9);
            a = longint'($urandom) & ((longint'(1) << N) - 1);
            b = longint'($urandom) & ((longint'(1) << N) - 1);
            if (mode == 0) b = 0;
            else if (mode == 1) b = 1;
            else if (mode == 2) b = $urandom_range(1, 3);
            else if (mode == 3) a = (longint'(1) << N) - 1;
            else if (mode == 4) a = 0;
            issue(a, b);
            wait_drain(N + 5);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        check("final_queue_empty", longint'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
